// File: rtl/cmp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_arbiter
//  Purpose  : Shares one subtractor-based comparator between two requesters
//             (port 0 = branch unit, port 1 = ALU SLT/SLTU path). Requests
//             are arbitrated round-robin, compared with a single WIDTH+1 bit
//             subtract, and returned through a one-entry registered response
//             stage with valid/ready backpressure (latency 1 cycle).
//  Ports    :
//    clk          in   rising-edge clock
//    reset        in   synchronous active-high reset
//    req_valid    in   [NREQ]        per-requester request valid
//    req_ready    out  [NREQ]        per-requester accept (one-hot or zero)
//    req_a/req_b  in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//    req_op       in   [NREQ*3]      funct3: 000 EQ 001 NE 100 LT 101 GE
//                                    110 LTU 111 GEU (010/011 illegal)
//    rsp_valid    out  response valid
//    rsp_ready    in   response consumer ready
//    rsp_id       out  requester that owns the response
//    rsp_result   out  comparison outcome
//    rsp_illegal  out  op was 010 or 011 (result forced to 0)
//  Options  : define CMP_ARB_FIXED_PRIORITY_EN to make port 0 always win a
//             tie (port 1 may starve); otherwise arbitration is round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic                  rsp_result,
    output logic                  rsp_illegal
);

    // funct3 encodings
    localparam logic [2:0] C_OP_EQ  = 3'b000;
    localparam logic [2:0] C_OP_NE  = 3'b001;
    localparam logic [2:0] C_OP_LT  = 3'b100;
    localparam logic [2:0] C_OP_GE  = 3'b101;
    localparam logic [2:0] C_OP_LTU = 3'b110;
    localparam logic [2:0] C_OP_GEU = 3'b111;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic   r_rsp_id;
    logic   r_rsp_result;
    logic   r_rsp_illegal;

    logic   w_can_accept;
    logic   w_accept;
    logic   w_consume;
    logic   w_grant;
    logic [NREQ-1:0] w_grant_oh;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_op;
    logic [WIDTH:0]   w_diff;
    logic             w_eq;
    logic             w_lts;
    logic             w_ltu;
    logic             w_result;
    logic             w_illegal;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign rsp_valid    = (r_state == ST_FULL);
    assign w_consume    = rsp_valid & rsp_ready;
    // A consumed response frees the register in the same cycle, so a new
    // request can be taken while the old one leaves (full throughput).
    assign w_can_accept = (r_state == ST_EMPTY) | w_consume;
    assign w_accept     = w_can_accept & (|req_valid);

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef CMP_ARB_FIXED_PRIORITY_EN
    // Port 0 wins every tie; no fairness state is kept.
    always_comb begin
        w_grant = 1'b0;
        if (!req_valid[0] && req_valid[1]) begin
            w_grant = 1'b1;
        end
    end
`else
    // Last granted requester; reset to 1 so port 0 wins the first tie.
    logic r_rr_last;

    always_comb begin
        w_grant = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            w_grant = ~r_rr_last;
        end else if (req_valid[1]) begin
            w_grant = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_grant;
        end
    end
`endif

    assign w_grant_oh = {w_grant, ~w_grant};
    assign req_ready  = w_accept ? w_grant_oh : '0;

    // ------------------------------------------------------------------------
    // Shared datapath on the granted operands
    // ------------------------------------------------------------------------
    assign w_a  = w_grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
    assign w_b  = w_grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    assign w_op = w_grant ? req_op[3 +: 3]        : req_op[0 +: 3];

    // A - B as A + ~B + 1; the carry out is the inverted borrow.
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_eq   = (w_diff[WIDTH-1:0] == '0);
    assign w_ltu  = ~w_diff[WIDTH];
    // When the signs differ the subtract may overflow, but the answer is
    // then simply "A is the negative one".
    assign w_lts  = (w_a[WIDTH-1] != w_b[WIDTH-1]) ? w_a[WIDTH-1]
                                                   : w_diff[WIDTH-1];

    always_comb begin
        w_result  = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            C_OP_EQ:  w_result = w_eq;
            C_OP_NE:  w_result = ~w_eq;
            C_OP_LT:  w_result = w_lts;
            C_OP_GE:  w_result = ~w_lts;
            C_OP_LTU: w_result = w_ltu;
            C_OP_GEU: w_result = ~w_ltu;
            default:  w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response payload only moves on accept, so it is held under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (w_accept) begin
            r_rsp_id      <= w_grant;
            r_rsp_result  <= w_result;
            r_rsp_illegal <= w_illegal;
        end
    end

    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_illegal = r_rsp_illegal;

endmodule
`default_nettype wire
